// File: rtl/arbiter_grant_mux.sv
// Payload mux behind a one-hot grant arbiter: selects the winning requester's data and
// forwards {data, src_id} through a 2-entry skid buffer with fully registered handshakes.
module arbiter_grant_mux #(
    parameter int unsigned P_REQUESTER_NUM = 3,
    parameter int unsigned P_DATA_W        = 32,
    localparam int unsigned P_SRC_ID_W     = (P_REQUESTER_NUM > 1) ? $clog2(P_REQUESTER_NUM) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [P_REQUESTER_NUM*P_DATA_W-1:0] req_data,
    input  logic [P_REQUESTER_NUM-1:0]          grant_valid,
    output logic                                grant_ready,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [P_DATA_W-1:0]                 m_data,
    output logic [P_SRC_ID_W-1:0]               m_src_id,
    output logic                                onehot_err
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [P_DATA_W-1:0]   main_data_q, main_data_d;
    logic [P_SRC_ID_W-1:0] main_id_q, main_id_d;
    logic [P_DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [P_SRC_ID_W-1:0] skid_id_q, skid_id_d;
    logic                  err_q, err_d;

    logic [P_DATA_W-1:0]   sel_data;
    logic [P_SRC_ID_W-1:0] sel_id;
    logic                  multi_hot;
    logic                  acc;
    logic                  pop;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        sel_data = '0;
        sel_id   = '0;
        for (int i = int'(P_REQUESTER_NUM) - 1; i >= 0; i--) begin
            if (grant_valid[i]) begin
                sel_data = req_data[i*P_DATA_W +: P_DATA_W];
                sel_id   = P_SRC_ID_W'(i);
            end
        end
    end

    assign multi_hot   = |(grant_valid & (grant_valid - P_REQUESTER_NUM'(1)));
    assign grant_ready = (state_q != StTwo);
    assign m_valid     = (state_q != StEmpty);
    assign acc         = (|grant_valid) && grant_ready;
    assign pop         = m_valid && m_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_id_d   = main_id_q;
        skid_data_d = skid_data_q;
        skid_id_d   = skid_id_q;
        err_d       = err_q | (acc & multi_hot);
        unique case (state_q)
            StEmpty: begin
                if (acc) begin
                    state_d     = StOne;
                    main_data_d = sel_data;
                    main_id_d   = sel_id;
                end
            end
            StOne: begin
                if (acc && !pop) begin
                    state_d     = StTwo;
                    skid_data_d = sel_data;
                    skid_id_d   = sel_id;
                end else if (acc && pop) begin
                    main_data_d = sel_data;
                    main_id_d   = sel_id;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    state_d     = StOne;
                    main_data_d = skid_data_q;
                    main_id_d   = skid_id_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_id_q   <= '0;
            skid_data_q <= '0;
            skid_id_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_id_q   <= main_id_d;
            skid_data_q <= skid_data_d;
            skid_id_q   <= skid_id_d;
            err_q       <= err_d;
        end
    end

    assign m_data     = main_data_q;
    assign m_src_id   = main_id_q;
    assign onehot_err = err_q;

endmodule

// File: tb/tb_arbiter_grant_mux.sv
// Bench for arbiter_grant_mux: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the buffer (FIFO of depth 2, lowest-index selection).
module tb_arbiter_grant_mux;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    grant_valid;
    logic            grant_ready;
    logic            m_valid;
    logic            m_ready;
    logic [DW-1:0]   m_data;
    logic [IW-1:0]   m_src_id;
    logic            onehot_err;

    ent_t q[$];
    bit   m_err;
    int   total = 0;
    int   bad   = 0;

    arbiter_grant_mux #(
        .P_REQUESTER_NUM(N),
        .P_DATA_W       (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_data   (req_data),
        .grant_valid(grant_valid),
        .grant_ready(grant_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_src_id   (m_src_id),
        .onehot_err (onehot_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model at the edge, then compare all outputs.
    task automatic cycle(input logic r, input logic [N-1:0] gv, input logic mr);
        bit   acc, pop;
        int   g, lo;
        ent_t e;
        rst         = r;
        grant_valid = gv;
        m_ready     = mr;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            acc = (gv != 0) && (q.size() < 2);
            pop = (q.size() > 0) && mr;
            if (acc) begin
                g    = int'(gv);
                lo   = $clog2(g & -g);
                e.id = IW'(lo);
                e.d  = req_data[lo*DW +: DW];
                if ($countones(gv) > 1) m_err = 1'b1;
            end
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
        check_eq("m_valid", 64'(m_valid), 64'(q.size() > 0));
        check_eq("grant_ready", 64'(grant_ready), 64'(q.size() < 2));
        check_eq("onehot_err", 64'(onehot_err), 64'(m_err));
        if (q.size() > 0) begin
            check_eq("m_data", 64'(m_data), 64'(q[0].d));
            check_eq("m_src_id", 64'(m_src_id), 64'(q[0].id));
        end else if (r) begin
            check_eq("rst_m_data", 64'(m_data), 64'(0));
            check_eq("rst_m_src_id", 64'(m_src_id), 64'(0));
        end
    endtask

    initial begin
        int pat[10] = '{0, 1, 2, 0, 1, 0, 2, 0, 1, 0};
        int cnt[3];
        int sel;
        logic [N-1:0] gv;

        rst         = 1'b1;
        grant_valid = '0;
        m_ready     = 1'b0;
        req_data    = {32'hC2, 32'hB1, 32'hA0};

        // Reset with all grants asserted: nothing captured.
        repeat (3) cycle(1'b1, 3'b111, 1'b1);

        // Streaming, one cycle latency, grant_ready stays high.
        cycle(1'b0, 3'b001, 1'b1);
        check_eq("stream_d0", 64'(m_data), 64'h A0);
        cycle(1'b0, 3'b010, 1'b1);
        check_eq("stream_d1", 64'(m_data), 64'h B1);
        cycle(1'b0, 3'b100, 1'b1);
        check_eq("stream_id2", 64'(m_src_id), 64'd2);
        cycle(1'b0, 3'b000, 1'b1);

        // Backpressure fills both entries, then drains in order.
        cycle(1'b0, 3'b010, 1'b0);
        cycle(1'b0, 3'b100, 1'b0);
        check_eq("bp_ready_low", 64'(grant_ready), 64'd0);
        cycle(1'b0, 3'b001, 1'b0);
        check_eq("bp_held", 64'(m_data), 64'h B1);
        cycle(1'b0, 3'b000, 1'b1);
        check_eq("bp_second", 64'(m_data), 64'h C2);
        check_eq("bp_ready_back", 64'(grant_ready), 64'd1);
        cycle(1'b0, 3'b000, 1'b1);

        // Accept and pop in the same cycle while holding one entry.
        cycle(1'b0, 3'b001, 1'b0);
        cycle(1'b0, 3'b100, 1'b1);
        check_eq("accpop_data", 64'(m_data), 64'h C2);
        cycle(1'b0, 3'b000, 1'b1);

        // Multi-hot grant: lowest index forwarded, error is sticky.
        cycle(1'b0, 3'b110, 1'b1);
        check_eq("err_id", 64'(m_src_id), 64'd1);
        check_eq("err_flag", 64'(onehot_err), 64'd1);
        repeat (3) cycle(1'b0, 3'b000, 1'b1);
        check_eq("err_sticky", 64'(onehot_err), 64'd1);

        // Randomized traffic with occasional mid-operation resets.
        for (int k = 0; k < 2000; k++) begin
            req_data = {$urandom, $urandom, $urandom};
            sel = int'($urandom_range(0, 9));
            if (sel < 2) gv = '0;
            else if (sel < 8) gv = N'(1 << $urandom_range(0, N - 1));
            else gv = N'($urandom);
            cycle(($urandom_range(0, 99) == 0), gv, $urandom_range(0, 3) != 0);
        end

        // Weighted round-robin grant pattern {5,3,2}, downstream always ready.
        req_data = {32'hC2, 32'hB1, 32'hA0};
        cycle(1'b1, 3'b000, 1'b1);
        cnt = '{0, 0, 0};
        for (int k = 0; k < 100; k++) begin
            cycle(1'b0, N'(1 << pat[k % 10]), 1'b1);
            if (m_valid && m_src_id < 3) cnt[m_src_id]++;
        end
        cycle(1'b0, 3'b000, 1'b1);
        check_eq("wrr_cnt0", 64'(cnt[0] >= 49 && cnt[0] <= 51), 64'd1);
        check_eq("wrr_cnt1", 64'(cnt[1] >= 29 && cnt[1] <= 31), 64'd1);
        check_eq("wrr_cnt2", 64'(cnt[2] >= 19 && cnt[2] <= 21), 64'd1);
        check_eq("wrr_total", 64'(cnt[0] + cnt[1] + cnt[2]), 64'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
